fpu_op_sequencer: RTL

//  Synthesizable, parametrised successor to the FPU testbench driver. Queues FPU

---
 rtl/fpu_op_sequencer_if.sv | 31 +++
 rtl/fpu_op_sequencer.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/fpu_op_sequencer_if.sv
// Request/response handshake bundle between a stimulus source and fpu_op_sequencer.
// The master drives requests and accepts responses; the slave is the sequencer.
interface fpu_op_sequencer_if #(
    parameter int FPUOP_W = 8,
    parameter int RM_W    = 2,
    parameter int FPCSR_W = 14
);
    logic               req_valid;
    logic               req_ready;
    logic [FPUOP_W-1:0] req_op;
    logic [RM_W-1:0]    req_rm;
    logic [31:0]        req_a;
    logic [31:0]        req_b;

    logic               rsp_valid;
    logic               rsp_ready;
    logic [31:0]        rsp_result;
    logic               rsp_cmp;
    logic [FPCSR_W-1:0] rsp_fpcsr;
    logic               rsp_timeout;

    modport master (
        output req_valid, req_op, req_rm, req_a, req_b, rsp_ready,
        input  req_ready, rsp_valid, rsp_result, rsp_cmp, rsp_fpcsr, rsp_timeout
    );

    modport slave (
        input  req_valid, req_op, req_rm, req_a, req_b, rsp_ready,
        output req_ready, rsp_valid, rsp_result, rsp_cmp, rsp_fpcsr, rsp_timeout
    );
endinterface

// File: rtl/fpu_op_sequencer.sv
// Queues FPU requests and walks each one through the mor1kx FPU pin protocol:
// decode, execute, wait for valid (with watchdog), respond, flush, drain.
module fpu_op_sequencer #(
    parameter int DEPTH   = 4,
    parameter int FPUOP_W = 8,
    parameter int RM_W    = 2,
    parameter int FPCSR_W = 14,
    parameter int TIMEOUT = 64
) (
    input  logic               clk,
    input  logic               rst,
    fpu_op_sequencer_if.slave  bus,
    output logic               busy,
    output logic               fpu_flush,
    output logic               fpu_decode,
    output logic               fpu_execute,
    output logic [FPUOP_W-1:0] fpu_op,
    output logic [RM_W-1:0]    fpu_rm,
    output logic [31:0]        fpu_opa,
    output logic [31:0]        fpu_opb,
    input  logic [31:0]        fpu_out,
    input  logic               fpu_valid_arith,
    input  logic               fpu_cmp,
    input  logic               fpu_valid_cmp,
    input  logic [FPCSR_W-1:0] fpu_fpcsr
);
    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;
    localparam int CW = $clog2(TIMEOUT) + 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);
    localparam logic [CW-1:0] CNT_MAX  = '1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_DECODE,
        S_EXEC,
        S_WAIT,
        S_RESP,
        S_FLUSH,
        S_DRAIN
    } state_t;

    typedef struct packed {
        logic [FPUOP_W-1:0] op;
        logic [RM_W-1:0]    rm;
        logic [31:0]        a;
        logic [31:0]        b;
    } req_t;

    req_t               fifo_mem [DEPTH];
    req_t               head;
    logic [PW-1:0]      wr_ptr;
    logic [PW-1:0]      rd_ptr;
    logic               full;
    logic               empty;
    logic               push;
    logic               pop;

    state_t             state;
    state_t             state_n;
    logic [CW-1:0]      cnt;
    logic               is_cmp;
    logic               result_hit;
    logic               cnt_last;
    logic               drain_done;

    logic [31:0]        rsp_result_q;
    logic               rsp_cmp_q;
    logic [FPCSR_W-1:0] rsp_fpcsr_q;
    logic               rsp_timeout_q;

    // Extra pointer MSB distinguishes full from empty when the index bits match.
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign empty = (wr_ptr == rd_ptr);
    assign push  = bus.req_valid && !full;
    assign head  = fifo_mem[rd_ptr[AW-1:0]];

    assign is_cmp     = fpu_op[3];
    assign result_hit = is_cmp ? fpu_valid_cmp : fpu_valid_arith;
    assign cnt_last   = (cnt == CNT_LAST);
    assign drain_done = (fpu_out == 32'd0) || cnt_last;

    assign bus.req_ready   = !full;
    assign bus.rsp_result  = rsp_result_q;
    assign bus.rsp_cmp     = rsp_cmp_q;
    assign bus.rsp_fpcsr   = rsp_fpcsr_q;
    assign bus.rsp_timeout = rsp_timeout_q;
    assign busy            = (state != S_IDLE) || !empty;

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr[AW-1:0]] <= {bus.req_op, bus.req_rm, bus.req_a, bus.req_b};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n          = state;
        pop              = 1'b0;
        fpu_decode       = 1'b0;
        fpu_execute      = 1'b0;
        fpu_flush        = 1'b0;
        bus.rsp_valid    = 1'b0;
        case (state)
            S_IDLE: begin
                if (!empty) begin
                    pop     = 1'b1;
                    state_n = S_DECODE;
                end
            end
            S_DECODE: begin
                fpu_decode = 1'b1;
                state_n    = S_EXEC;
            end
            S_EXEC: begin
                fpu_execute = 1'b1;
                state_n     = S_WAIT;
            end
            S_WAIT: begin
                if (result_hit || cnt_last) begin
                    state_n = S_RESP;
                end
            end
            S_RESP: begin
                bus.rsp_valid = 1'b1;
                if (bus.rsp_ready) begin
                    state_n = S_FLUSH;
                end
            end
            S_FLUSH: begin
                fpu_flush = 1'b1;
                state_n   = S_DRAIN;
            end
            S_DRAIN: begin
                if (drain_done) begin
                    state_n = S_IDLE;
                end
            end
            default: state_n = S_IDLE;
        endcase
    end

    // Operand registers stay put for the whole op and return to zero once it drains.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fpu_op  <= '0;
            fpu_rm  <= '0;
            fpu_opa <= '0;
            fpu_opb <= '0;
        end else if (pop) begin
            fpu_op  <= head.op;
            fpu_rm  <= head.rm;
            fpu_opa <= head.a;
            fpu_opb <= head.b;
        end else if (state == S_DRAIN && drain_done) begin
            fpu_op  <= '0;
            fpu_rm  <= '0;
            fpu_opa <= '0;
            fpu_opb <= '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (state == S_EXEC || state == S_FLUSH) begin
            cnt <= '0;
        end else if ((state == S_WAIT || state == S_DRAIN) && cnt != CNT_MAX) begin
            cnt <= cnt + CW'(1);
        end
    end

    // A real result wins over the watchdog if both land in the same cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rsp_result_q  <= '0;
            rsp_cmp_q     <= 1'b0;
            rsp_fpcsr_q   <= '0;
            rsp_timeout_q <= 1'b0;
        end else if (state == S_WAIT) begin
            if (result_hit) begin
                rsp_result_q  <= is_cmp ? 32'd0 : fpu_out;
                rsp_cmp_q     <= is_cmp ? fpu_cmp : 1'b0;
                rsp_fpcsr_q   <= fpu_fpcsr;
                rsp_timeout_q <= 1'b0;
            end else if (cnt_last) begin
                rsp_result_q  <= '0;
                rsp_cmp_q     <= 1'b0;
                rsp_fpcsr_q   <= '0;
                rsp_timeout_q <= 1'b1;
            end
        end else if (state == S_RESP && bus.rsp_ready) begin
            rsp_result_q  <= '0;
            rsp_cmp_q     <= 1'b0;
            rsp_fpcsr_q   <= '0;
            rsp_timeout_q <= 1'b0;
        end
    end
endmodule
